// File: rtl/ddr2_local_pkg.sv
// Shared types and default widths for the DDR2 local-port burst master.
// eff_size maps a zero burst size to a single beat.
package ddr2_local_pkg;

  localparam int DEF_ADDR_W = 25;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = 4;
  localparam int DEF_SIZE_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_ISSUE
  } state_t;

  function automatic logic [7:0] eff_size(input logic [7:0] s);
    return (s == 8'd0) ? 8'd1 : s;
  endfunction

endpackage

// File: rtl/ddr2_local_burst_master_if.sv
// User command/data channels plus the DDR2 controller local port.
// master: burst master view; slave: user and controller side.
interface ddr2_local_burst_master_if
  import ddr2_local_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BE_W   = DEF_BE_W,
  parameter int SIZE_W = DEF_SIZE_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [SIZE_W-1:0] cmd_size;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              rd_err;
  logic              local_init_done;
  logic              local_ready;
  logic [ADDR_W-1:0] local_address;
  logic [SIZE_W-1:0] local_size;
  logic              local_burstbegin;
  logic              local_read_req;
  logic              local_write_req;
  logic [DATA_W-1:0] local_wdata;
  logic [BE_W-1:0]   local_be;
  logic [DATA_W-1:0] local_rdata;
  logic              local_rdata_valid;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size,
    input  wr_valid, wr_data, wr_be,
    input  local_init_done, local_ready,
    input  local_rdata, local_rdata_valid,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output busy, rd_err,
    output local_address, local_size, local_burstbegin,
    output local_read_req, local_write_req,
    output local_wdata, local_be
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size,
    output wr_valid, wr_data, wr_be,
    output local_init_done, local_ready,
    output local_rdata, local_rdata_valid,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  busy, rd_err,
    input  local_address, local_size, local_burstbegin,
    input  local_read_req, local_write_req,
    input  local_wdata, local_be
  );

endinterface

// File: rtl/ddr2_rd_credit_tracker.sv
// Outstanding read-beat counter with credit check and sticky
// underflow flag for returns that arrive with nothing outstanding.
module ddr2_rd_credit_tracker
  import ddr2_local_pkg::*;
#(
  parameter int SIZE_W     = DEF_SIZE_W,
  parameter int MAX_RD_OUT = 16,
  parameter int OUT_W      = $clog2(MAX_RD_OUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SIZE_W-1:0] i_chk_size,
  input  logic              i_add,
  input  logic [SIZE_W-1:0] i_add_size,
  input  logic              i_dec,
  output logic              o_credit_ok,
  output logic [OUT_W-1:0]  o_outstanding,
  output logic              o_rd_err
);

  localparam int SUM_W = ((OUT_W > SIZE_W) ? OUT_W : SIZE_W) + 1;

  logic [OUT_W-1:0] r_out;
  logic             r_err;
  logic [SUM_W-1:0] w_sum;
  logic             w_under;
  logic [OUT_W-1:0] w_add_v;
  logic [OUT_W-1:0] w_dec_v;

  assign w_sum   = SUM_W'(r_out) + SUM_W'(i_chk_size);
  assign w_under = i_dec && (r_out == '0);
  assign w_add_v = i_add ? OUT_W'(i_add_size) : '0;
  assign w_dec_v = (i_dec && !w_under) ? OUT_W'(1) : '0;

  assign o_credit_ok   = (w_sum <= SUM_W'(MAX_RD_OUT));
  assign o_outstanding = r_out;
  assign o_rd_err      = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_err <= 1'b0;
    end else begin
      r_out <= r_out + w_add_v - w_dec_v;
      if (w_under) r_err <= 1'b1;
    end
  end

endmodule

// File: rtl/ddr2_local_burst_master.sv
// DDR2 local-port burst master: user commands/write beats in, read beats out.
// Optional counters via DDR2_LOCAL_BURST_MASTER_PERF_EN.
module ddr2_local_burst_master
  import ddr2_local_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BE_W       = DEF_BE_W,
  parameter int SIZE_W     = DEF_SIZE_W,
  parameter int MAX_RD_OUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  ddr2_local_burst_master_if.master bus
`ifdef DDR2_LOCAL_BURST_MASTER_PERF_EN
  ,
  output logic [31:0] perf_wr_beats,
  output logic [31:0] perf_rd_beats,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam int OUT_W = $clog2(MAX_RD_OUT + 1);

  state_t            r_state;
  logic              r_en;
  logic              r_first;
  logic [SIZE_W-1:0] r_beats;
  logic [ADDR_W-1:0] r_laddr;
  logic [SIZE_W-1:0] r_lsize;
  logic              r_bb;
  logic              r_rd_req;
  logic              r_wr_req;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  logic [SIZE_W-1:0] w_eff;
  logic              w_credit_ok;
  logic [OUT_W-1:0]  w_outstanding;
  logic              w_rd_err;
  logic              w_cmd_ready;
  logic              w_cmd_acc;
  logic              w_wr_ready;
  logic              w_wr_load;
  logic              w_wr_acc;
  logic              w_rd_acc;

  assign w_eff = SIZE_W'(eff_size(8'(bus.cmd_size)));

  // r_en keeps cmd_ready low until the first clock after reset release
  assign w_cmd_ready = r_en && (r_state == IDLE) && bus.local_init_done
                    && (bus.cmd_write || w_credit_ok);
  assign w_cmd_acc  = bus.cmd_valid && w_cmd_ready;
  assign w_wr_acc   = r_wr_req && bus.local_ready;
  assign w_rd_acc   = (r_state == RD_ISSUE) && bus.local_ready;
  // only take beats not yet loaded into the request register
  assign w_wr_ready = (r_state == WR_BURST)
                   && (!r_wr_req || bus.local_ready)
                   && (r_beats > SIZE_W'(r_wr_req));
  assign w_wr_load  = bus.wr_valid && w_wr_ready;

  ddr2_rd_credit_tracker #(
    .SIZE_W    (SIZE_W),
    .MAX_RD_OUT(MAX_RD_OUT)
  ) u_credit (
    .clk          (clk),
    .rst_n        (reset_n),
    .i_chk_size   (w_eff),
    .i_add        (w_rd_acc),
    .i_add_size   (r_lsize),
    .i_dec        (bus.local_rdata_valid),
    .o_credit_ok  (w_credit_ok),
    .o_outstanding(w_outstanding),
    .o_rd_err     (w_rd_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_en       <= 1'b0;
      r_first    <= 1'b0;
      r_beats    <= '0;
      r_laddr    <= '0;
      r_lsize    <= '0;
      r_bb       <= 1'b0;
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_en       <= 1'b1;
      r_rd_valid <= bus.local_rdata_valid;
      r_rd_data  <= bus.local_rdata;
      unique case (r_state)
        IDLE: begin
          if (w_cmd_acc) begin
            r_laddr <= bus.cmd_addr;
            r_lsize <= w_eff;
            r_beats <= w_eff;
            if (bus.cmd_write) begin
              r_state <= WR_BURST;
              r_first <= 1'b1;
            end else begin
              r_state  <= RD_ISSUE;
              r_rd_req <= 1'b1;
              r_bb     <= 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (w_wr_acc) r_beats <= r_beats - SIZE_W'(1);
          if (w_wr_load) begin
            r_wr_req <= 1'b1;
            r_wdata  <= bus.wr_data;
            r_be     <= bus.wr_be;
            r_bb     <= r_first;
            r_first  <= 1'b0;
          end else if (w_wr_acc) begin
            r_wr_req <= 1'b0;
            r_bb     <= 1'b0;
          end
          if (w_wr_acc && (r_beats == SIZE_W'(1))) r_state <= IDLE;
        end
        RD_ISSUE: begin
          if (bus.local_ready) begin
            r_rd_req <= 1'b0;
            r_bb     <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready        = w_cmd_ready;
  assign bus.wr_ready         = w_wr_ready;
  assign bus.rd_valid         = r_rd_valid;
  assign bus.rd_data          = r_rd_data;
  assign bus.busy             = (r_state != IDLE) || (w_outstanding != '0);
  assign bus.rd_err           = w_rd_err;
  assign bus.local_address    = r_laddr;
  assign bus.local_size       = r_lsize;
  assign bus.local_burstbegin = r_bb;
  assign bus.local_read_req   = r_rd_req;
  assign bus.local_write_req  = r_wr_req;
  assign bus.local_wdata      = r_wdata;
  assign bus.local_be         = r_be;

`ifdef DDR2_LOCAL_BURST_MASTER_PERF_EN
  logic [31:0] r_pwr;
  logic [31:0] r_prd;
  logic [31:0] r_pst;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwr <= '0;
      r_prd <= '0;
      r_pst <= '0;
    end else begin
      if (w_wr_acc && !(&r_pwr)) r_pwr <= r_pwr + 32'd1;
      if (bus.local_rdata_valid && !(&r_prd)) r_prd <= r_prd + 32'd1;
      if ((r_wr_req || r_rd_req) && !bus.local_ready && !(&r_pst))
        r_pst <= r_pst + 32'd1;
    end
  end

  assign perf_wr_beats     = r_pwr;
  assign perf_rd_beats     = r_prd;
  assign perf_stall_cycles = r_pst;
`endif

endmodule
